// File: rtl/fir_mac_multi.sv
// -----------------------------------------------------------------------------
// fir_mac_multi
//
// Multi-channel FIR multiply-accumulate engine. One coefficient stream, read
// from an external synchronous ROM with one cycle of read latency, is shared
// by NUM_CH sample channels. A rising edge on `sequencing` starts a frame of
// NUM_TAPS MAC cycles. At the end of the frame each channel's accumulator is
// scaled down to DATA_W bits and presented on smpl_out with a one-cycle
// out_vld pulse.
//
// Frame timeline (E = edge that samples the rising edge of sequencing):
//   E+1            PRIME  : ROM is reading address 0
//   E+2 .. E+1+N   ACCUM  : tap k uses coef_data = c[k], smpl_in = x[k]
//   E+2+N          DONE   : results latched, out_vld asserted after this edge
//
// Optional build macro:
//   FIR_SAT_EN  - when defined, output scaling is an arithmetic right shift
//                 by FRAC_SHIFT followed by saturation to the signed DATA_W
//                 range. When undefined, output scaling is plain truncation
//                 acc[FRAC_SHIFT+DATA_W-1 : FRAC_SHIFT].
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   sequencing  frame request, rising edge starts (or restarts) a frame
//   smpl_in     per-channel samples, channel c at [c*DATA_W +: DATA_W]
//   coef_data   ROM read data, valid the cycle after coef_addr
//   coef_addr   ROM read address
//   tap_idx     tap being accumulated; upstream presents sample tap_idx
//   busy        high whenever the engine is not idle
//   out_vld     one-cycle pulse when smpl_out carries new results
//   smpl_out    per-channel results, same packing as smpl_in
// -----------------------------------------------------------------------------
module fir_mac_multi #(
   parameter  int NUM_TAPS   = 1021,
   parameter  int DATA_W     = 16,
   parameter  int COEF_W     = 16,
   parameter  int NUM_CH     = 2,
   parameter  int ACC_W      = 32,
   parameter  int FRAC_SHIFT = 15,
   localparam int ADDR_W     = $clog2(NUM_TAPS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sequencing,
   input  logic [NUM_CH*DATA_W-1:0] smpl_in,
   input  logic [COEF_W-1:0]        coef_data,
   output logic [ADDR_W-1:0]        coef_addr,
   output logic [ADDR_W-1:0]        tap_idx,
   output logic                     busy,
   output logic                     out_vld,
   output logic [NUM_CH*DATA_W-1:0] smpl_out
);

   localparam int                PROD_W   = COEF_W + DATA_W;
   localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      ACCUM = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state_q;
   state_t state_d;

   logic seq_ff;
   logic pos_seq;

   logic signed [ACC_W-1:0]  acc_q   [NUM_CH];
   logic signed [ACC_W-1:0]  acc_nxt [NUM_CH];
   logic signed [PROD_W-1:0] prod    [NUM_CH];
   logic [DATA_W-1:0]        res_q   [NUM_CH];
   logic [DATA_W-1:0]        scaled  [NUM_CH];
   logic [ADDR_W-1:0]        addr_step;

   // --------------------------------------------------------------------------
   // Output scaling: accumulator -> DATA_W result
   // --------------------------------------------------------------------------
   function automatic logic [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] a);
`ifdef FIR_SAT_EN
      logic signed [ACC_W-1:0] sh;
      logic [ACC_W-DATA_W:0]   hi;
      sh = a >>> FRAC_SHIFT;
      // The value fits in DATA_W signed bits only when every bit from the
      // DATA_W sign position upward agrees.
      hi = sh[ACC_W-1:DATA_W-1];
      if ((hi == '0) || (hi == '1)) begin
         return sh[DATA_W-1:0];
      end else if (sh[ACC_W-1]) begin
         return {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         return {1'b0, {(DATA_W-1){1'b1}}};
      end
`else
      return a[FRAC_SHIFT+DATA_W-1:FRAC_SHIFT];
`endif
   endfunction

   // --------------------------------------------------------------------------
   // Request edge detect
   // --------------------------------------------------------------------------
   assign pos_seq = sequencing & ~seq_ff;

   // NOTE: clocked state is written with non-blocking assignments so every
   // flop samples the values from before the edge, regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_ff <= 1'b0;
      end else begin
         seq_ff <= sequencing;
      end
   end

   // --------------------------------------------------------------------------
   // FSM
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: the default assignment at the top keeps this block purely
   // combinational; without it, any path that skips state_d infers a latch.
   always_comb begin
      state_d = state_q;
      if (pos_seq) begin
         // A new request wins in every state, including the DONE latch cycle.
         state_d = PRIME;
      end else begin
         unique case (state_q)
            IDLE:    state_d = IDLE;
            PRIME:   state_d = ACCUM;
            ACCUM:   state_d = (tap_idx == LAST_TAP) ? DONE : ACCUM;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   assign busy = (state_q != IDLE);

   // --------------------------------------------------------------------------
   // Per-channel multiply, accumulate and scale
   // --------------------------------------------------------------------------
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         // Both operands are signed, so they are sign-extended to PROD_W
         // before the multiply and the product is exact.
         prod[c]    = $signed(coef_data) * $signed(smpl_in[c*DATA_W +: DATA_W]);
         acc_nxt[c] = acc_q[c] + ACC_W'(prod[c]);
         scaled[c]  = scale(acc_q[c]);
      end
   end

   // ROM runs two addresses ahead of the tap being accumulated, parking on
   // the last address once it is reached.
   always_comb begin
      addr_step = LAST_TAP;
      if (int'(tap_idx) + 2 < NUM_TAPS - 1) begin
         addr_step = tap_idx + ADDR_W'(2);
      end
   end

   // --------------------------------------------------------------------------
   // Datapath registers
   // --------------------------------------------------------------------------
   // NOTE: the accumulator and result arrays are small register banks, not
   // RAM, so they take the asynchronous reset like every other flop here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coef_addr <= '0;
         tap_idx   <= '0;
         out_vld   <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            acc_q[c] <= '0;
            res_q[c] <= '0;
         end
      end else begin
         out_vld <= 1'b0;
         if (pos_seq) begin
            // Start or abort-and-restart: results of an aborted frame are
            // dropped, smpl_out keeps the last completed frame.
            coef_addr <= '0;
            tap_idx   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
               acc_q[c] <= '0;
            end
         end else begin
            unique case (state_q)
               IDLE: begin
                  coef_addr <= '0;
               end
               PRIME: begin
                  coef_addr <= ADDR_W'(1);
                  tap_idx   <= '0;
               end
               ACCUM: begin
                  for (int c = 0; c < NUM_CH; c++) begin
                     acc_q[c] <= acc_nxt[c];
                  end
                  tap_idx   <= tap_idx + ADDR_W'(1);
                  coef_addr <= addr_step;
               end
               DONE: begin
                  for (int c = 0; c < NUM_CH; c++) begin
                     res_q[c] <= scaled[c];
                  end
                  out_vld   <= 1'b1;
                  coef_addr <= '0;
                  tap_idx   <= '0;
               end
               default: begin
                  coef_addr <= '0;
                  tap_idx   <= '0;
               end
            endcase
         end
      end
   end

   // --------------------------------------------------------------------------
   // Output packing
   // --------------------------------------------------------------------------
   always_comb begin
      smpl_out = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         smpl_out[c*DATA_W +: DATA_W] = res_q[c];
      end
   end

endmodule

// File: tb/tb_fir_mac_multi.sv
// -----------------------------------------------------------------------------
// tb_fir_mac_multi
//
// Directed bench for fir_mac_multi with NUM_TAPS=4, NUM_CH=2, ACC_W=40.
// A registered ROM model and a tap-indexed sample table stand in for the
// coefficient ROM and the upstream sample queues. Each scenario task drives
// one frame and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_fir_mac_multi;

   localparam int NT = 4;
   localparam int DW = 16;
   localparam int CW = 16;
   localparam int NC = 2;
   localparam int AW = 2;
   localparam int LOG_N = 20;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              sequencing;
   logic [NC*DW-1:0]  smpl_in;
   logic [CW-1:0]     coef_data = '0;
   logic [AW-1:0]     coef_addr;
   logic [AW-1:0]     tap_idx;
   logic              busy;
   logic              out_vld;
   logic [NC*DW-1:0]  smpl_out;

   logic [CW-1:0]     rom    [NT];
   logic [DW-1:0]     x0_tab [NT];
   logic [DW-1:0]     x1_tab [NT];

   logic              vld_log  [LOG_N];
   logic              busy_log [LOG_N];
   logic [AW-1:0]     addr_log [LOG_N];
   logic [AW-1:0]     tap_log  [LOG_N];
   logic [NC*DW-1:0]  out_cap;
   int                first_vld;
   int                n_vld;

   logic [AW-1:0]     exp_addr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};

   int total = 0;
   int bad   = 0;

   fir_mac_multi #(
      .NUM_TAPS   (NT),
      .DATA_W     (DW),
      .COEF_W     (CW),
      .NUM_CH     (NC),
      .ACC_W      (40),
      .FRAC_SHIFT (15)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sequencing (sequencing),
      .smpl_in    (smpl_in),
      .coef_data  (coef_data),
      .coef_addr  (coef_addr),
      .tap_idx    (tap_idx),
      .busy       (busy),
      .out_vld    (out_vld),
      .smpl_out   (smpl_out)
   );

   always #5 clk = ~clk;

   // Synchronous ROM, one cycle read latency.
   always @(posedge clk) coef_data <= rom[coef_addr];

   // Upstream presents sample k while tap_idx == k.
   assign smpl_in = {x1_tab[tap_idx], x0_tab[tap_idx]};

   task automatic fill(input logic [CW-1:0] c, input logic [DW-1:0] x0v,
                       input logic [DW-1:0] x1v);
      for (int k = 0; k < NT; k++) begin
         rom[k]    = c;
         x0_tab[k] = x0v;
         x1_tab[k] = x1v;
      end
   endtask

   // Raises sequencing, then logs outputs at the negedge after each of the
   // next LOG_N rising edges (index 0 = the edge that sees the request).
   task automatic run_frame(input int restart_i, input bit hold);
      @(negedge clk);
      sequencing = 1'b1;
      first_vld  = -1;
      n_vld      = 0;
      for (int i = 0; i < LOG_N; i++) begin
         @(posedge clk);
         @(negedge clk);
         vld_log[i]  = out_vld;
         busy_log[i] = busy;
         addr_log[i] = coef_addr;
         tap_log[i]  = tap_idx;
         if (out_vld === 1'b1) begin
            n_vld++;
            if (first_vld < 0) begin
               first_vld = i;
               out_cap   = smpl_out;
            end
         end
         if (!hold && i == 0) sequencing = 1'b0;
         if (i == restart_i) sequencing = 1'b1;
         if (i == restart_i + 1) sequencing = 1'b0;
      end
      sequencing = 1'b0;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      sequencing = 1'b0;
      fill(16'h0000, 16'h0000, 16'h0000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (smpl_out !== 32'h0) begin bad++; $display("FAIL reset_smpl_out got=%h want=%h", smpl_out, 32'h0); end
      total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL reset_out_vld got=%b want=0", out_vld); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (coef_addr !== 2'd0) begin bad++; $display("FAIL reset_coef_addr got=%0d want=0", coef_addr); end
      total++; if (tap_idx !== 2'd0) begin bad++; $display("FAIL reset_tap_idx got=%0d want=0", tap_idx); end
   endtask

   task automatic test_dc();
      // 0x4000*0x1000 = 2^26, four taps = 2^28, >>15 = 0x2000 (ch1 negated).
      fill(16'h4000, 16'h1000, 16'hF000);
      run_frame(-1, 1'b0);
      total++; if (first_vld !== 6) begin bad++; $display("FAIL dc_latency got=%0d want=6", first_vld); end
      total++; if (n_vld !== 1) begin bad++; $display("FAIL dc_pulses got=%0d want=1", n_vld); end
      total++; if (out_cap !== 32'hE000_2000) begin bad++; $display("FAIL dc_result got=%h want=%h", out_cap, 32'hE000_2000); end
      total++; if (busy_log[5] !== 1'b1) begin bad++; $display("FAIL dc_busy_done got=%b want=1", busy_log[5]); end
      total++; if (busy_log[7] !== 1'b0) begin bad++; $display("FAIL dc_busy_after got=%b want=0", busy_log[7]); end
      total++; if (smpl_out !== 32'hE000_2000) begin bad++; $display("FAIL dc_hold got=%h want=%h", smpl_out, 32'hE000_2000); end
   endtask

   task automatic test_impulse();
      fill(16'h0000, 16'h0000, 16'h0000);
      rom[0]    = 16'h7FFF;
      x0_tab[0] = 16'h7FFF;
      run_frame(-1, 1'b0);
      total++; if (out_cap[15:0] !== 16'h7FFE) begin bad++; $display("FAIL impulse_ch0 got=%h want=7ffe", out_cap[15:0]); end
      total++; if (out_cap[31:16] !== 16'h0000) begin bad++; $display("FAIL impulse_ch1 got=%h want=0000", out_cap[31:16]); end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (addr_log[i] !== exp_addr[i]) begin
            bad++;
            $display("FAIL impulse_addr[%0d] got=%0d want=%0d", i, addr_log[i], exp_addr[i]);
         end
      end
      total++; if (addr_log[6] !== 2'd0) begin bad++; $display("FAIL impulse_addr_idle got=%0d want=0", addr_log[6]); end
   endtask

   task automatic test_overflow();
      logic [31:0] want;
`ifdef FIR_SAT_EN
      want = 32'h8000_7FFF;
`else
      want = 32'h0004_FFF8;
`endif
      fill(16'h7FFF, 16'h7FFF, 16'h8000);
      run_frame(-1, 1'b0);
      total++; if (n_vld !== 1) begin bad++; $display("FAIL ovf_pulses got=%0d want=1", n_vld); end
      total++; if (out_cap !== want) begin bad++; $display("FAIL ovf_result got=%h want=%h", out_cap, want); end
   endtask

   task automatic test_restart();
      fill(16'h4000, 16'h1000, 16'hF000);
      run_frame(3, 1'b0);
      total++; if (tap_log[3] !== 2'd2) begin bad++; $display("FAIL restart_tap got=%0d want=2", tap_log[3]); end
      total++; if (vld_log[6] !== 1'b0) begin bad++; $display("FAIL restart_first_frame got=%b want=0", vld_log[6]); end
      total++; if (first_vld !== 10) begin bad++; $display("FAIL restart_latency got=%0d want=10", first_vld); end
      total++; if (n_vld !== 1) begin bad++; $display("FAIL restart_pulses got=%0d want=1", n_vld); end
      total++; if (out_cap !== 32'hE000_2000) begin bad++; $display("FAIL restart_result got=%h want=%h", out_cap, 32'hE000_2000); end
   endtask

   task automatic test_hold();
      // 0x4000*0x0800*4 >>15 = 0x1000; 0x4000*0x2000*4 >>15 = 0x4000.
      fill(16'h4000, 16'h0800, 16'h2000);
      run_frame(-1, 1'b1);
      total++; if (n_vld !== 1) begin bad++; $display("FAIL hold_pulses got=%0d want=1", n_vld); end
      total++; if (first_vld !== 6) begin bad++; $display("FAIL hold_latency got=%0d want=6", first_vld); end
      total++; if (out_cap !== 32'h4000_1000) begin bad++; $display("FAIL hold_result got=%h want=%h", out_cap, 32'h4000_1000); end
      total++; if (smpl_out !== 32'h4000_1000) begin bad++; $display("FAIL hold_stable got=%h want=%h", smpl_out, 32'h4000_1000); end
   endtask

   task automatic test_reset_mid();
      int pulses;
      pulses = 0;
      fill(16'h4000, 16'h1000, 16'hF000);
      @(negedge clk);
      sequencing = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sequencing = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
      rst_n = 1'b0;
      #1;
      total++; if (smpl_out !== 32'h0) begin bad++; $display("FAIL midrst_smpl_out got=%h want=%h", smpl_out, 32'h0); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
      total++; if (tap_idx !== 2'd0) begin bad++; $display("FAIL midrst_tap_idx got=%0d want=0", tap_idx); end
      total++; if (coef_addr !== 2'd0) begin bad++; $display("FAIL midrst_coef_addr got=%0d want=0", coef_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_vld === 1'b1) pulses++;
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_pulses got=%0d want=0", pulses); end
      total++; if (smpl_out !== 32'h0) begin bad++; $display("FAIL midrst_after got=%h want=%h", smpl_out, 32'h0); end
   endtask

   initial begin
      test_reset();
      test_dc();
      test_impulse();
      test_overflow();
      test_restart();
      test_hold();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
